// File: rtl/isp_matrix_3x3_rgb.sv
// isp_matrix_3x3_rgb: streaming 3x3 RGB neighbourhood generator with zero padding at frame edges
module isp_matrix_3x3_rgb #(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_HDISP  = 640
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    per_frame_vsync,
    input  logic                    per_frame_hsync,
    input  logic                    per_frame_href,
    input  logic [DATA_WIDTH-1:0]   per_img_red,
    input  logic [DATA_WIDTH-1:0]   per_img_green,
    input  logic [DATA_WIDTH-1:0]   per_img_blue,
    output logic                    post_matrix_frame_vsync,
    output logic                    post_matrix_frame_hsync,
    output logic                    post_matrix_frame_href,
    output logic [27*DATA_WIDTH-1:0] post_matrix_rgb,
    output logic                    line_overflow
);
    localparam int PW = 3 * DATA_WIDTH;
    localparam int XW = IMG_HDISP > 1 ? $clog2(IMG_HDISP) : 1;
    localparam logic [XW-1:0] XMAX = XW'(IMG_HDISP - 1);

    logic          vsync_d, href_d, seen_low, full;
    logic          frame_start, full_cur, line_adv;
    logic [XW-1:0] col, x_cur, x1;
    logic [1:0]    ln, ln_cur, vs_q, hs_q, href_q;
    logic [PW-1:0] pix, r1, r2, r3;
    logic [PW-1:0] lb1 [IMG_HDISP];
    logic [PW-1:0] lb2 [IMG_HDISP];
    logic [PW-1:0] w [9];

    // a frame start overrides the stored counters in the same cycle so a
    // coinciding pixel lands at column 0 of line 0
    assign pix         = {per_img_red, per_img_green, per_img_blue};
    assign frame_start = vsync_d & ~per_frame_vsync;
    assign x_cur       = frame_start ? '0 : col;
    assign ln_cur      = frame_start ? 2'd0 : ln;
    assign full_cur    = ~frame_start & full;
    // seen_low keeps the tail of a line interrupted by reset from counting as a line
    assign line_adv    = href_d & ~per_frame_href & seen_low & ~frame_start;

    // line/column position tracking and sticky overflow detection
    always_ff @(posedge clk) begin
        if (rst) begin
            vsync_d       <= 1'b1;
            href_d        <= 1'b0;
            seen_low      <= 1'b0;
            full          <= 1'b0;
            col           <= '0;
            ln            <= 2'd0;
            line_overflow <= 1'b0;
        end else begin
            vsync_d       <= per_frame_vsync;
            href_d        <= per_frame_href;
            seen_low      <= seen_low | ~per_frame_href | frame_start;
            col           <= per_frame_href ? (x_cur == XMAX ? XMAX : x_cur + 1'b1) : '0;
            full          <= per_frame_href & (full_cur | x_cur == XMAX);
            ln            <= line_adv ? ln_cur + {1'b0, ln_cur != 2'd2} : ln_cur;
            line_overflow <= (line_overflow & ~frame_start) | (per_frame_href & full_cur);
        end
    end

    // line buffers (read-before-write) and first pipeline stage with row masking
    always_ff @(posedge clk) begin
        if (per_frame_href) begin
            lb1[x_cur] <= pix;
            lb2[x_cur] <= lb1[x_cur];
        end
        r1 <= ln_cur == 2'd2 ? lb2[x_cur] : '0;
        r2 <= ln_cur != 2'd0 ? lb1[x_cur] : '0;
        r3 <= pix;
        x1 <= x_cur;
    end

    // two-clock sync delay line
    always_ff @(posedge clk) begin
        if (rst) begin
            vs_q   <= 2'b11;
            hs_q   <= 2'b11;
            href_q <= 2'b00;
        end else begin
            vs_q   <= {vs_q[0], per_frame_vsync};
            hs_q   <= {hs_q[0], per_frame_hsync};
            href_q <= {href_q[0], per_frame_href};
        end
    end

    // window shift: new column enters at column 3, left columns masked near x=0
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) w[k] <= '0;
        end else if (href_q[0]) begin
            for (int r = 0; r < 3; r++) begin
                w[3*r+2] <= r == 0 ? r1 : r == 1 ? r2 : r3;
                w[3*r+1] <= x1 != '0 ? w[3*r+2] : '0;
                w[3*r]   <= x1 > XW'(1) ? w[3*r+1] : '0;
            end
        end
    end

    assign post_matrix_frame_vsync = vs_q[1];
    assign post_matrix_frame_hsync = hs_q[1];
    assign post_matrix_frame_href  = href_q[1];

    for (genvar k = 0; k < 9; k++) begin : g_pack
        assign post_matrix_rgb[k*PW +: PW] = w[k];
    end
endmodule

// File: tb/tb_isp_matrix_3x3_rgb.sv
// tb_isp_matrix_3x3_rgb: directed scenarios checked against a zero-padded window model
module tb_isp_matrix_3x3_rgb;
    localparam int DW = 8;
    localparam int HD = 8;

    logic clk = 1'b0, rst = 1'b1, vsync = 1'b1, hsync = 1'b1, href = 1'b0;
    logic [DW-1:0] red = '0, green = '0, blue = '0;
    logic ov, oh, ohr, ovf;
    logic [27*DW-1:0] orgb;

    isp_matrix_3x3_rgb #(.DATA_WIDTH(DW), .IMG_HDISP(HD)) dut (
        .clk(clk), .rst(rst),
        .per_frame_vsync(vsync), .per_frame_hsync(hsync), .per_frame_href(href),
        .per_img_red(red), .per_img_green(green), .per_img_blue(blue),
        .post_matrix_frame_vsync(ov), .post_matrix_frame_hsync(oh),
        .post_matrix_frame_href(ohr), .post_matrix_rgb(orgb), .line_overflow(ovf)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;
    logic [23:0] img [16][9];
    int cur_y = 0, cur_x = 0, scen = 0, in_cnt = 0, out_cnt = 0;
    bit known = 1'b1, pk = 1'b1, go = 1'b0, cnt_on = 1'b0;

    task automatic chk(input string nm, input logic [215:0] a, input logic [215:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    // zero-padded 3x3 window ending at (y,x) of the current frame image
    function automatic logic [215:0] win(input int y, input int x);
        logic [215:0] v;
        int yy, xx;
        v = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                yy = y - 2 + r;
                xx = x - 2 + c;
                if (yy >= 0 && xx >= 0) v[(r*3+c)*24 +: 24] = img[yy][xx];
            end
        return v;
    endfunction

    logic s1_v, s1_h, s1_hr, e_v, e_h, e_hr, s1_known, e_known;
    logic [215:0] s1_rgb, e_rgb;
    int s1_y, s1_x, e_y, e_x;

    always @(posedge clk) begin
        if (rst) begin
            s1_v = 1; s1_h = 1; s1_hr = 0; e_v = 1; e_h = 1; e_hr = 0;
            e_rgb = '0; e_known = 1; s1_known = 1; e_y = -1; e_x = -1;
        end else begin
            e_v = s1_v; e_h = s1_h; e_hr = s1_hr;
            if (s1_hr) begin
                e_rgb = s1_rgb; e_known = s1_known; e_y = s1_y; e_x = s1_x;
            end
            s1_v = vsync; s1_h = hsync; s1_hr = href; s1_known = pk;
            s1_y = cur_y; s1_x = cur_x;
            s1_rgb = href ? win(cur_y, cur_x) : '0;
        end
    end

    always @(negedge clk) begin
        if (go) begin
            chk("vsync_out", 216'(ov), 216'(e_v));
            chk("hsync_out", 216'(oh), 216'(e_h));
            chk("href_out", 216'(ohr), 216'(e_hr));
            if (e_known) chk("window", orgb, e_rgb);
            if (cnt_on && ohr) out_cnt++;
            if (e_hr && e_known) begin
                if (scen == 1 && e_y == 0 && e_x == 2) begin
                    chk("s1_row3_x2", 216'(orgb[215:144]), 216'({24'h030303, 24'h020202, 24'h010101}));
                    chk("s1_upper_x2", 216'(orgb[143:0]), '0);
                end
                if (scen == 1 && e_y == 0 && e_x == 0)
                    chk("s1_row3_x0", 216'(orgb[215:144]), 216'({24'h010101, 48'h0}));
                if (scen == 2 && e_y == 2 && e_x == 3)
                    chk("s2_win_y2_x3", orgb, {24'h232323, 24'h222222, 24'h212121,
                                               24'h131313, 24'h121212, 24'h111111,
                                               24'h030303, 24'h020202, 24'h010101});
                if ((scen == 3 || scen == 5) && e_y == 0)
                    chk("line0_upper_zero", 216'(orgb[143:0]), '0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic vpulse();
        vsync = 1'b0; tick();
        vsync = 1'b1; known = 1'b1; tick();
    endtask

    task automatic drive(input int y, input int x, input int mode);
        logic [23:0] v;
        v = mode == 2 ? 24'($urandom) : {3{8'(mode == 0 ? x + 1 : 16 * y + x)}};
        if (x >= HD) known = 1'b0;
        img[y][x] = v;
        {red, green, blue} = v;
        cur_y = y; cur_x = x; pk = known; href = 1'b1;
        if (cnt_on) in_cnt++;
        tick();
    endtask

    task automatic line(input int y, input int n, input int mode);
        hsync = 1'b0; tick();
        hsync = 1'b1; tick();
        for (int x = 0; x < n; x++) drive(y, x, mode);
        href = 1'b0;
        tick(); tick(); tick();
    endtask

    initial begin
        tick(); go = 1'b1; tick(); tick();
        rst = 1'b0; tick();
        chk("reset_href", 216'(ohr), '0);
        chk("reset_rgb", orgb, '0);
        chk("reset_ovf", 216'(ovf), '0);
        scen = 1; vpulse(); line(0, 8, 0);
        scen = 2; vpulse(); for (int y = 0; y < 3; y++) line(y, 8, 1);
        scen = 3; vpulse(); line(0, 8, 1); line(1, 8, 1);
        scen = 4; vpulse(); line(0, 8, 1);
        chk("ovf_before", 216'(ovf), '0);
        line(1, 9, 1);
        chk("ovf_set", 216'(ovf), 216'(1));
        line(2, 8, 1);
        chk("ovf_sticky", 216'(ovf), 216'(1));
        vpulse();
        chk("ovf_cleared", 216'(ovf), '0);
        scen = 5; vpulse(); line(0, 8, 1);
        hsync = 1'b0; tick(); hsync = 1'b1; tick();
        for (int x = 0; x < 4; x++) drive(1, x, 1);
        rst = 1'b1; drive(1, 4, 1);
        chk("rst_mid_href", 216'(ohr), '0);
        chk("rst_mid_vsync", 216'(ov), 216'(1));
        chk("rst_mid_hsync", 216'(oh), 216'(1));
        chk("rst_mid_rgb", orgb, '0);
        chk("rst_mid_ovf", 216'(ovf), '0);
        rst = 1'b0; cnt_on = 1'b1; known = 1'b0;
        for (int x = 5; x < 8; x++) drive(1, x, 1);
        href = 1'b0; tick(); tick(); tick();
        known = 1'b1;
        for (int y = 0; y < 3; y++) line(y, 8, 1);
        tick();
        cnt_on = 1'b0;
        chk("href_count_after_rst", 216'(out_cnt), 216'(in_cnt));
        scen = 6;
        for (int f = 0; f < 2; f++) begin
            vpulse();
            for (int y = 0; y < 10; y++) line(y, 8, 2);
        end
        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/isp_matrix_3x3_rgb.md
ISP_MATRIX_3X3_RGB -- requirements
Module: isp_matrix_3x3_rgb

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, bits per colour channel.
REQ-002 SHALL have parameter IMG_HDISP, default 640, maximum active pixels per line and the line-buffer depth.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port per_frame_vsync, input, 1, frame sync, active-low pulse, idle 1.
REQ-006 SHALL have port per_frame_hsync, input, 1, line sync, active-low pulse, idle 1.
REQ-007 SHALL have port per_frame_href, input, 1, pixel valid.
REQ-008 SHALL have ports per_img_red, per_img_green and per_img_blue, input, DATA_WIDTH each, the input pixel.
REQ-009 SHALL have ports post_matrix_frame_vsync, post_matrix_frame_hsync and post_matrix_frame_href, output, 1 each, the delayed syncs.
REQ-010 SHALL have port post_matrix_rgb, output, 27*DATA_WIDTH, the 3x3 window.
- Nine packed {R,G,B} words.
- Word k = p11,p12,p13,p21,p22,p23,p31,p32,p33 for k=0..8, with p11 at the LSBs.
REQ-011 SHALL have port line_overflow, output, 1, sticky flag set when a line exceeds IMG_HDISP pixels.

Function
REQ-012 SHALL detect frame start on the falling edge of per_frame_vsync (registered compare).
REQ-013 SHALL clear the line counter and the column counter at frame start.
REQ-014 SHALL advance the line counter on each falling edge of per_frame_href; the counter saturates at 2 (values 0, 1, 2+).
REQ-015 SHALL increment the column counter on each cycle with per_frame_href=1.
REQ-016 SHALL reset the column counter to 0 on the per_frame_href falling edge.
REQ-017 SHALL hold the column counter at IMG_HDISP-1 when a line exceeds IMG_HDISP pixels, and SHALL set line_overflow.
- Excess pixels overwrite the last buffer entry.
- line_overflow clears only at frame start or on rst.
REQ-018 SHALL contain two line buffers, each IMG_HDISP x 3*DATA_WIDTH, with read-before-write semantics per address.
- Buffer1[x] receives the current pixel.
- Buffer2[x] receives the prior content of buffer1[x].
REQ-019 SHALL form window rows as follows:
- Row 3 (p31..p33) = current line y.
- Row 2 = line y-1.
- Row 1 = line y-2.
REQ-020 SHALL form window columns as follows:
- Column 3 (p13,p23,p33) = column x.
- Column 2 = x-1.
- Column 1 = x-2.
REQ-021 SHALL drive zero for any window position outside the frame.
- Rows 1 and 2 are zero while line counter=0.
- Row 1 is zero while line counter=1.
- Columns 1 and 2 are zero when x=0; column 1 is zero when x=1.
- Stale buffer contents from a previous frame never appear.
REQ-022 SHALL have a fixed latency of exactly 2 clocks from input pixel (x,y) with href=1 to post_matrix_rgb showing the window ending at (x,y) with post_matrix_frame_href=1.
REQ-023 SHALL delay per_frame_vsync, per_frame_hsync and per_frame_href by the same 2 clocks onto the post_matrix_frame_* outputs, with no other alteration.
REQ-024 SHALL hold post_matrix_rgb at its last value while post_matrix_frame_href=0.
REQ-025 SHALL NOT stall, apply backpressure or drop pixels; one pixel per clock is sustained indefinitely.
REQ-026 SHALL handle a frame start that coincides with href=1 as follows:
- The pixel is treated as column 0 of line 0 of the new frame.
- The column-zero rule of REQ-021 applies.

Reset
REQ-027 SHALL, while rst=1, drive:
- post_matrix_frame_vsync=1 and post_matrix_frame_hsync=1.
- post_matrix_frame_href=0 and post_matrix_rgb=0.
- line_overflow=0.
- Counters and the sync delay line at their idle values.
REQ-028 SHALL NOT require clearing of line-buffer RAM; REQ-021 masking covers its contents.
REQ-029 SHALL treat the first line after a mid-frame reset release as line 0 (rows 1 and 2 zero) until the line counter advances, and SHALL NOT produce spurious href pulses.

Verification
REQ-030 SHALL be covered by scenario "first line, IMG_HDISP=8, vsync pulse then 8 pixels R=G=B=x+1":
- Stimulus: vsync pulse, then 8 pixels with R=G=B=x+1.
- Output href is high 2 clocks later for 8 cycles.
- Row 3 at x=2 reads 1,2,3.
- Rows 1 and 2 read 0.
- At x=0, p31=p32=0 and p33=1.
REQ-031 SHALL be covered by scenario "three lines, pixel value 16*y+x":
- At line 2, x=3, the window reads p11=2,p12=3,p13=4? No: it reads p11..p13 = 1,2,3, p21..p23 = 17,18,19 and p31..p33 = 33,34,35.
REQ-032 SHALL be covered by scenario "second frame after a full first frame":
- Line 0 of frame 2 shows rows 1 and 2 all zero, despite non-zero buffer contents.
REQ-033 SHALL be covered by scenario "9-pixel line with IMG_HDISP=8":
- line_overflow goes 1 and stays 1 through the frame.
- line_overflow clears after the next vsync falling edge.
- The sync delay stays exactly 2.
REQ-034 SHALL be covered by scenario "rst=1 for 1 clock mid-line":
- All outputs are at reset values on the next clock.
- The following line produces zero upper rows.
- Output href count equals the input href count after release, minus nothing.
REQ-035 SHALL be covered by scenario "random RGB, 10 lines x 8 pixels x 2 frames":
- Output is compared every cycle against a software 3x3 zero-padded window model delayed 2 clocks.
- Zero mismatches are allowed.
